gpio8_in_cond: RTL and testbench



---
 rtl/gpio8_pkg.sv | 13 +
 rtl/gpio8_debounce_bit.sv | 66 ++++++
 rtl/gpio8_in_cond.sv | 130 +++++++++++++
 tb/tb_gpio8_in_cond.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio8_pkg.sv
// Shared constants and types for the GPIO8 input-conditioning stage.
package gpio8_pkg;

  localparam logic [1:0] GPIO8C_STAT = 2'd0;
  localparam logic [1:0] GPIO8C_IEN  = 2'd1;
  localparam logic [1:0] GPIO8C_PEND = 2'd2;
  localparam logic [1:0] GPIO8C_DIV  = 2'd3;

  localparam int DB_CNT_W = 4;

  typedef logic [7:0] gpio8_byte_t;

endpackage

// File: rtl/gpio8_debounce_bit.sv
// One pad: 2-flop synchronizer followed by a tick-based debounce counter.
// Debounce is present only when GPIO8_DEBOUNCE_EN is defined; otherwise stable follows sync.
module gpio8_debounce_bit
  import gpio8_pkg::*;
#(
  parameter int DB_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic pad_i,
  output logic stable_o
);

  logic [1:0] sync_q;

  // Two-stage synchronizer; sync_q[1] is the metastability-safe level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pad_i};
    end
  end

`ifdef GPIO8_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                stable_q, stable_d;

  // Count ticks while sync disagrees with stable; accept on the DB_CNT-th tick
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_q[1] == stable_q) begin
      cnt_d = {DB_CNT_W{1'b0}};
    end else if (tick_i) begin
      if (cnt_q == DB_CNT_W'(DB_CNT - 1)) begin
        stable_d = sync_q[1];
        cnt_d    = {DB_CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Debounce state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= {DB_CNT_W{1'b0}};
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
`else
  logic [DB_CNT_W:0] unused_s;
  assign unused_s = {tick_i, DB_CNT_W'(DB_CNT)};
  assign stable_o = sync_q[1];
`endif

endmodule

// File: rtl/gpio8_in_cond.sv
// GPIO8 input conditioning: per-pin sync/debounce, edge detect, sticky IRQ pending, bus slave.
// Optional macro GPIO8_DEBOUNCE_EN enables the tick prescaler, DIV register and debounce.
module gpio8_in_cond
  import gpio8_pkg::*;
#(
  parameter int DB_CNT = 4,
  parameter int DIV_W  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_mem_valid,
  input  logic [1:0]  i_mem_addr,
  input  logic        i_mem_wen,
  input  logic [31:0] i_mem_wdata,
  output logic        o_mem_ready,
  output logic [31:0] o_mem_rdata,
  input  logic [7:0]  i_pad_in,
  output logic [7:0]  o_gpio_in,
  output logic        o_irq
);

  logic        wr_s;
  logic        tick_s;
  logic [31:0] div_rd_s;
  gpio8_byte_t stable_s, stable_prev_q, rise_s, fall_s;
  logic [15:0] ien_q, ien_d, pend_q, pend_d, pend_clr_s;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q;
  logic [31:0] unused_wdata_s;

  assign wr_s           = i_mem_valid & i_mem_wen;
  assign unused_wdata_s = i_mem_wdata;

`ifdef GPIO8_DEBOUNCE_EN
  logic [DIV_W-1:0] div_q, div_d, pre_q, pre_d;

  assign tick_s   = (pre_q == div_q);
  assign div_rd_s = 32'(div_q);

  // Prescaler runs 0..DIV; a DIV write restarts the phase
  always_comb begin
    div_d = div_q;
    pre_d = pre_q;
    if (wr_s && (i_mem_addr == GPIO8C_DIV)) begin
      div_d = i_mem_wdata[DIV_W-1:0];
      pre_d = {DIV_W{1'b0}};
    end else if (tick_s) begin
      pre_d = {DIV_W{1'b0}};
    end else begin
      pre_d = pre_q + DIV_W'(1);
    end
  end

  // Prescaler registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= {DIV_W{1'b0}};
      pre_q <= {DIV_W{1'b0}};
    end else begin
      div_q <= div_d;
      pre_q <= pre_d;
    end
  end
`else
  logic [DIV_W-1:0] unused_div_s;
  assign unused_div_s = {DIV_W{1'b0}};
  assign tick_s       = 1'b0;
  assign div_rd_s     = 32'd0;
`endif

  for (genvar i = 0; i < 8; i++) begin : g_pin
    gpio8_debounce_bit #(.DB_CNT(DB_CNT)) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (tick_s),
      .pad_i    (i_pad_in[i]),
      .stable_o (stable_s[i])
    );
  end

  // Edge detect on the debounced level, IEN/PEND next-state and read mux
  always_comb begin
    rise_s     = stable_s & ~stable_prev_q;
    fall_s     = ~stable_s & stable_prev_q;
    ien_d      = ien_q;
    pend_clr_s = 16'd0;
    if (wr_s && (i_mem_addr == GPIO8C_IEN)) begin
      ien_d = i_mem_wdata[15:0];
    end else begin
      ien_d = ien_q;
    end
    if (wr_s && (i_mem_addr == GPIO8C_PEND)) begin
      pend_clr_s = i_mem_wdata[15:0];
    end else begin
      pend_clr_s = 16'd0;
    end
    // A new edge overrides a concurrent write-1-to-clear
    pend_d = {fall_s & ien_q[15:8], rise_s & ien_q[7:0]} | (pend_q & ~pend_clr_s);
    case (i_mem_addr)
      GPIO8C_STAT: rdata_d = {24'd0, stable_s};
      GPIO8C_IEN:  rdata_d = {16'd0, ien_q};
      GPIO8C_PEND: rdata_d = {16'd0, pend_q};
      GPIO8C_DIV:  rdata_d = div_rd_s;
      default:     rdata_d = 32'd0;
    endcase
  end

  // Control/status registers, edge history, IRQ and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_prev_q <= 8'd0;
      ien_q         <= 16'd0;
      pend_q        <= 16'd0;
      irq_q         <= 1'b0;
      rdata_q       <= 32'd0;
    end else begin
      stable_prev_q <= stable_s;
      ien_q         <= ien_d;
      pend_q        <= pend_d;
      irq_q         <= |pend_q;
      rdata_q       <= rdata_d;
    end
  end

  assign o_mem_ready = 1'b1;
  assign o_mem_rdata = rdata_q;
  assign o_gpio_in   = stable_s;
  assign o_irq       = irq_q;

endmodule

// File: tb/tb_gpio8_in_cond.sv
// Directed self-checking bench for gpio8_in_cond (both GPIO8_DEBOUNCE_EN builds).
module tb_gpio8_in_cond;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_mem_valid;
  logic [1:0]  i_mem_addr;
  logic        i_mem_wen;
  logic [31:0] i_mem_wdata;
  logic        o_mem_ready;
  logic [31:0] o_mem_rdata;
  logic [7:0]  i_pad_in;
  logic [7:0]  o_gpio_in;
  logic        o_irq;

`ifdef GPIO8_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  localparam logic [1:0] A_STAT = 2'd0;
  localparam logic [1:0] A_IEN  = 2'd1;
  localparam logic [1:0] A_PEND = 2'd2;
  localparam logic [1:0] A_DIV  = 2'd3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio8_in_cond #(.DB_CNT(4), .DIV_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mem_valid (i_mem_valid),
    .i_mem_addr  (i_mem_addr),
    .i_mem_wen   (i_mem_wen),
    .i_mem_wdata (i_mem_wdata),
    .o_mem_ready (o_mem_ready),
    .o_mem_rdata (o_mem_rdata),
    .i_pad_in    (i_pad_in),
    .o_gpio_in   (o_gpio_in),
    .o_irq       (o_irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    i_mem_valid = 1'b1;
    i_mem_wen   = 1'b1;
    i_mem_addr  = a;
    i_mem_wdata = d;
    @(negedge clk);
    i_mem_valid = 1'b0;
    i_mem_wen   = 1'b0;
    i_mem_wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    i_mem_addr = a;
    @(negedge clk);
    d = o_mem_rdata;
  endtask

  task automatic pad_latency(input string tag, input logic [7:0] v, input logic [7:0] old);
    i_pad_in = v;
    step(LAT - 1);
    check_eq({tag, "_early"}, {24'd0, o_gpio_in}, {24'd0, old});
    step(1);
    check_eq(tag, {24'd0, o_gpio_in}, {24'd0, v});
  endtask

  initial begin
    logic [31:0] rd;
    logic        seen;
    rst_n       = 1'b0;
    i_mem_valid = 1'b0;
    i_mem_wen   = 1'b0;
    i_mem_addr  = A_STAT;
    i_mem_wdata = 32'd0;
    i_pad_in    = 8'h00;
    step(2);
    check_eq("rst_gpio", {24'd0, o_gpio_in}, 32'd0);
    check_eq("rst_irq", {31'd0, o_irq}, 32'd0);
    check_eq("rst_rdata", o_mem_rdata, 32'd0);
    check_eq("ready", {31'd0, o_mem_ready}, 32'd1);
    rst_n = 1'b1;
    step(1);

    // Rise interrupt on pin 0
    bus_write(A_IEN, 32'h0000_0001);
    bus_read(A_IEN, rd);  check_eq("ien_rb", rd, 32'h0000_0001);
    bus_read(A_STAT, rd); check_eq("stat0", rd, 32'h0000_0000);
    pad_latency("rise0", 8'h01, 8'h00);
    check_eq("irq_before_pend", {31'd0, o_irq}, 32'd0);
    step(1);
    check_eq("irq_lag", {31'd0, o_irq}, 32'd0);
    step(1);
    check_eq("irq_rise", {31'd0, o_irq}, 32'd1);
    bus_read(A_PEND, rd); check_eq("pend_rise0", rd, 32'h0000_0001);
    bus_write(A_PEND, 32'h0000_0001);
    step(1);
    check_eq("irq_w1c", {31'd0, o_irq}, 32'd0);
    bus_read(A_PEND, rd); check_eq("pend_w1c", rd, 32'h0000_0000);

    // Fall on pin 3 without enable, then with fall enable
    bus_write(A_IEN, 32'h0000_0000);
    i_pad_in = 8'h09; step(LAT + 2);
    i_pad_in = 8'h01; step(LAT + 2);
    check_eq("fall3_lvl", {24'd0, o_gpio_in}, 32'h0000_0001);
    bus_read(A_PEND, rd); check_eq("fall3_noen", rd, 32'h0000_0000);
    check_eq("fall3_noirq", {31'd0, o_irq}, 32'd0);
    bus_write(A_IEN, 32'h0000_0800);
    i_pad_in = 8'h09; step(LAT + 2);
    i_pad_in = 8'h01; step(LAT + 2);
    bus_read(A_PEND, rd); check_eq("fall3_en", rd, 32'h0000_0800);
    check_eq("fall3_irq", {31'd0, o_irq}, 32'd1);
    bus_write(A_IEN, 32'h0000_0000);
    bus_read(A_PEND, rd); check_eq("pend_keep", rd, 32'h0000_0800);
    bus_write(A_PEND, 32'h0000_FFFF);
    step(1);
    check_eq("irq_clr_all", {31'd0, o_irq}, 32'd0);

    // Set wins over a concurrent write-1-to-clear on pin 1
    bus_write(A_IEN, 32'h0000_0002);
    i_pad_in = 8'h03; step(LAT + 2);
    bus_read(A_PEND, rd); check_eq("pend_rise1", rd, 32'h0000_0002);
    i_pad_in = 8'h01; step(LAT + 2);
    i_pad_in = 8'h03; step(LAT);
    check_eq("sim_edge", {24'd0, o_gpio_in}, 32'h0000_0003);
    bus_write(A_PEND, 32'h0000_0002);
    bus_read(A_PEND, rd); check_eq("sim_pend", rd, 32'h0000_0002);
    check_eq("sim_irq", {31'd0, o_irq}, 32'd1);
    bus_write(A_PEND, 32'h0000_0002);
    bus_read(A_PEND, rd); check_eq("sim_after", rd, 32'h0000_0000);

    // Exact synchronizer/debounce latency on a multi-bit pattern
    pad_latency("lvl5a", 8'h5A, 8'h03);
    bus_read(A_STAT, rd); check_eq("stat5a", rd, 32'h0000_005A);

`ifdef GPIO8_DEBOUNCE_EN
    i_pad_in = 8'h00; step(LAT + 2);
    bus_write(A_DIV, 32'h0000_0009);
    bus_read(A_DIV, rd); check_eq("div_rb", rd, 32'h0000_0009);
    i_pad_in = 8'h01;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (o_gpio_in != 8'h00) seen = 1'b1;
    end
    i_pad_in = 8'h00;
    for (int k = 0; k < 60; k++) begin
      step(1);
      if (o_gpio_in != 8'h00) seen = 1'b1;
    end
    check_eq("glitch_reject", {31'd0, seen}, 32'd0);
    i_pad_in = 8'h01;
    seen = 1'b0;
    for (int k = 0; k < 51 && !seen; k++) begin
      step(1);
      if (o_gpio_in[0]) seen = 1'b1;
    end
    check_eq("db_hold", {31'd0, seen}, 32'd1);
    bus_read(A_STAT, rd); check_eq("db_stat", rd, 32'h0000_0001);
`else
    bus_write(A_DIV, 32'h0000_0010);
    bus_read(A_DIV, rd); check_eq("div_absent", rd, 32'h0000_0000);
`endif

    // Reset in the middle of activity with pending bits set
    bus_write(A_IEN, 32'h0000_00FF);
    i_pad_in = 8'hFF;
    step(80);
    check_eq("pre_rst_irq", {31'd0, o_irq}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst2_gpio", {24'd0, o_gpio_in}, 32'd0);
    check_eq("rst2_irq", {31'd0, o_irq}, 32'd0);
    check_eq("rst2_rdata", o_mem_rdata, 32'd0);
    step(2);
    rst_n      = 1'b1;
    i_mem_addr = A_PEND;
    for (int k = 1; k <= LAT; k++) begin
      step(1);
      if (k == 1) check_eq("rst2_pend", o_mem_rdata, 32'd0);
      if (k == LAT - 1) check_eq("rst2_lvl_early", {24'd0, o_gpio_in}, 32'd0);
      if (k == LAT) check_eq("rst2_lvl", {24'd0, o_gpio_in}, 32'h0000_00FF);
    end
    check_eq("rst2_irq_after", {31'd0, o_irq}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
